mem_access_stage: RTL and testbench

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

---
 rtl/mem_access_stage.sv | 144 ++++++++++++++
 tb/tb_mem_access_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory access stage: single loads/stores and LM/SM multi-word sequences
// against a one-request-at-a-time data memory with ack handshake.
module mem_access_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic        multi_load,
  input  logic [15:0] addr,
  input  logic [15:0] store_data,
  input  logic [7:0]  reg_mask,
  output logic [2:0]  rf_read_idx,
  input  logic [15:0] rf_read_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] MemData,
  output logic        mm_we,
  output logic [2:0]  mm_reg_idx,
  output logic        out_valid
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] WAIT  = 2'b01;
  localparam logic [1:0] MULTI = 2'b10;

  logic [1:0]  state;
  logic [15:0] cur_addr;
  logic [15:0] wdata_q;
  logic [15:0] mem_data_q;
  logic        we_q;
  logic        lm_q;
  logic [7:0]  mask_q;
  logic [2:0]  idx;
  logic [2:0]  mm_idx_q;
  logic        mm_we_q;
  logic        done_q;
  logic        accept;
  logic        last;

  // lowest set bit wins so words go out in ascending register order
  always_comb begin
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_q[i]) idx = 3'(i);
    end
  end

  assign in_ready    = (state == IDLE);
  assign accept      = in_valid && in_ready;
  assign last        = (mask_q & ~(8'd1 << idx)) == 8'd0;
  assign mem_req     = (state == WAIT) || (state == MULTI);
  assign mem_addr    = cur_addr;
  assign rf_read_idx = idx;
  assign MemData     = mem_data_q;
  assign mm_we       = mm_we_q;
  assign mm_reg_idx  = mm_idx_q;
  assign out_valid   = done_q;

  // decoded from state so an async reset drops them without a clock
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    unique case (1'b1)
      state == WAIT: mem_we = we_q;
      state == MULTI: begin
        mem_we    = !lm_q;
        mem_wdata = rf_read_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cur_addr   <= '0;
      wdata_q    <= '0;
      mem_data_q <= '0;
      we_q       <= 1'b0;
      lm_q       <= 1'b0;
      mask_q     <= '0;
      mm_idx_q   <= '0;
      mm_we_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      mm_we_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (op)
              2'b00: done_q <= 1'b1;
              2'b01, 2'b10: begin
                cur_addr <= addr;
                we_q     <= op[1];
                wdata_q  <= store_data;
                state    <= WAIT;
              end
              default: begin
                if (reg_mask == 8'd0) begin
                  done_q <= 1'b1;
                end else begin
                  cur_addr <= addr;
                  mask_q   <= reg_mask;
                  lm_q     <= multi_load;
                  state    <= MULTI;
                end
              end
            endcase
          end
        end
        WAIT: begin
          if (mem_ack) begin
            if (!we_q) mem_data_q <= mem_rdata;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end
        MULTI: begin
          if (mem_ack) begin
            if (lm_q) begin
              mem_data_q <= mem_rdata;
              mm_we_q    <= 1'b1;
              mm_idx_q   <= idx;
            end
            mask_q[idx] <= 1'b0;
            cur_addr    <= cur_addr + 16'd1;
            if (last) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage with a transaction-level
// memory/register-file model and cycle-exact latency expectations.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic        multi_load;
  logic [15:0] addr;
  logic [15:0] store_data;
  logic [7:0]  reg_mask;
  logic [2:0]  rf_read_idx;
  logic [15:0] rf_read_data;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] MemData;
  logic        mm_we;
  logic [2:0]  mm_reg_idx;
  logic        out_valid;

  logic [15:0] rf [8];
  logic [15:0] mem [65536];
  logic [15:0] exp_md;
  int          n_vec = 0;
  int          n_err = 0;

  assign rf_read_data = rf[rf_read_idx];

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .multi_load   (multi_load),
    .addr         (addr),
    .store_data   (store_data),
    .reg_mask     (reg_mask),
    .rf_read_idx  (rf_read_idx),
    .rf_read_data (rf_read_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .MemData      (MemData),
    .mm_we        (mm_we),
    .mm_reg_idx   (mm_reg_idx),
    .out_valid    (out_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble();
    op         = 2'($urandom);
    multi_load = 1'($urandom);
    addr       = 16'($urandom);
    store_data = 16'($urandom);
    reg_mask   = 8'($urandom);
  endtask

  // One instruction: build the expected word list, then run it cycle by cycle.
  task automatic run_op(input logic [1:0] o, input logic ml,
                        input logic [15:0] a, input logic [15:0] sd,
                        input logic [7:0] m, input int dly);
    logic [15:0] wa [8];
    logic        wwe [8];
    logic [15:0] wd [8];
    logic [2:0]  wi [8];
    int          d [8];
    int          n, lat, k, w;
    logic        pend, exp_req;
    logic [2:0]  pidx;
    logic [15:0] pdat, cur;
    n = 0; k = 0; w = 0; pend = 1'b0; pidx = '0; pdat = '0;
    if (o == 2'b01 || o == 2'b10) begin
      wa[0] = a; wwe[0] = o[1]; wd[0] = sd; wi[0] = '0; n = 1;
    end else if (o == 2'b11) begin
      cur = a;
      for (int i = 0; i < 8; i++) begin
        if (m[i]) begin
          wa[n] = cur; wwe[n] = !ml; wd[n] = rf[i]; wi[n] = 3'(i);
          n++; cur = cur + 16'd1;
        end
      end
    end
    lat = 1;
    for (int j = 0; j < n; j++) begin
      d[j] = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      lat += d[j] + 1;
    end
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1; op = o; multi_load = ml; addr = a;
    store_data = sd; reg_mask = m; mem_ack = 1'b0;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      scramble();
      exp_req = (n > 0) && (cyc < lat);
      chk("mm_we", mm_we, pend);
      if (pend) begin
        chk("mm_reg_idx", mm_reg_idx, pidx);
        chk("lm_word", MemData, pdat);
      end
      pend = 1'b0;
      chk("out_valid", out_valid, cyc == lat);
      chk("mem_req", mem_req, exp_req);
      chk("in_ready", in_ready, !exp_req);
      mem_ack = 1'b0;
      if (exp_req) begin
        chk("mem_addr", mem_addr, wa[k]);
        chk("mem_we", mem_we, wwe[k]);
        if (wwe[k]) chk("mem_wdata", mem_wdata, wd[k]);
        if (w == d[k]) begin
          mem_ack = 1'b1;
          if (wwe[k]) begin
            mem[wa[k]] = wd[k];
          end else begin
            mem_rdata = mem[wa[k]];
            exp_md = mem_rdata;
            if (o == 2'b11) begin
              pend = 1'b1; pidx = wi[k]; pdat = mem_rdata;
            end
          end
          k++; w = 0;
        end else begin
          w++;
          mem_rdata = 16'($urandom);
        end
        in_valid = 1'($urandom);
      end
    end
    chk("mem_data", MemData, exp_md);
  endtask

  task automatic idle(input int nc);
    for (int c = 0; c < nc; c++) begin
      in_valid = 1'b0;
      mem_ack = 1'($urandom);
      mem_rdata = 16'($urandom);
      @(negedge clk);
      chk("idle_req", mem_req, 0);
      chk("idle_out_valid", out_valid, 0);
      chk("idle_mm_we", mm_we, 0);
      chk("idle_ready", in_ready, 1);
      chk("idle_mem_data", MemData, exp_md);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    op = '0; multi_load = 1'b0; addr = '0; store_data = '0; reg_mask = '0;
    exp_md = '0;
    for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_memdata", MemData, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_mm_idx", mm_reg_idx, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mm_we", mm_we, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    mem[16'h0040] = 16'hBEEF;
    run_op(2'b01, 1'b0, 16'h0040, 16'h0000, 8'h00, 3);
    chk("beef", MemData, 16'hBEEF);
    idle(2);
    run_op(2'b10, 1'b0, 16'h0010, 16'h1234, 8'h00, 0);
    chk("store_mem", mem[16'h0010], 16'h1234);
    run_op(2'b11, 1'b1, 16'hFFFE, 16'h0000, 8'b1000_0101, -1);
    run_op(2'b11, 1'b0, 16'h0100, 16'h0000, 8'h00, 0);
    run_op(2'b00, 1'b0, 16'h0200, 16'h0000, 8'h00, 0);
    idle(4);

    // abort an LM after its first word
    in_valid = 1'b1; op = 2'b11; multi_load = 1'b1;
    addr = 16'h0300; reg_mask = 8'b0000_0110;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_req1", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("abort_req2", mem_req, 1);
    chk("abort_mm_we", mm_we, 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_req_now", mem_req, 0);
    chk("abort_we_now", mem_we, 0);
    chk("abort_mm_now", mm_we, 0);
    chk("abort_ov_now", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_memdata", MemData, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_md = '0;
    chk("abort_addr", mem_addr, 0);
    chk("abort_mm_idx", mm_reg_idx, 0);
    run_op(2'b01, 1'b0, 16'h0400, 16'h0000, 8'h00, 1);

    for (int t = 0; t < 300; t++) begin
      logic [1:0]  o;
      logic [15:0] a;
      logic [7:0]  m;
      o = 2'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                      : 16'($urandom);
      m = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      run_op(o, 1'($urandom), a, 16'($urandom), m, -1);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
